// File: rtl/mips_exec_unit_if.sv
// mips_exec_unit_if: operand, decode, next-PC candidate and result bundle for mips_exec_unit
// master drives operands/decode/control (clk_enable, alu_op, opcode, funct, shamt, a, b,
//   branch_addr, jump_addr, read_data_a, pc_plus4, condition_met, jump1, jump2, branch)
// slave returns results (alu_out, zero, hi, lo, tgt_addr, pc_next)
interface mips_exec_unit_if;
   logic        clk_enable;
   logic [1:0]  alu_op;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_out;
   logic        zero;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] branch_addr;
   logic [31:0] jump_addr;
   logic [31:0] read_data_a;
   logic [31:0] pc_plus4;
   logic        condition_met;
   logic        jump1;
   logic        jump2;
   logic        branch;
   logic [31:0] tgt_addr;
   logic [31:0] pc_next;
   modport master (
      output clk_enable, alu_op, opcode, funct, shamt, a, b,
             branch_addr, jump_addr, read_data_a, pc_plus4,
             condition_met, jump1, jump2, branch,
      input  alu_out, zero, hi, lo, tgt_addr, pc_next
   );
   modport slave (
      input  clk_enable, alu_op, opcode, funct, shamt, a, b,
             branch_addr, jump_addr, read_data_a, pc_plus4,
             condition_met, jump1, jump2, branch,
      output alu_out, zero, hi, lo, tgt_addr, pc_next
   );
endinterface

// File: rtl/mips_exec_unit.sv
// mips_exec_unit: combinational MIPS ALU plus delay-slot-aware next-PC target register
// ports: clk, reset (sync, active-high), bus (mips_exec_unit_if.slave)
// MIPS_EXEC_MULTDIV_EN enables MULT/MULTU/DIV/DIVU onto hi/lo; otherwise those codes yield zero
module mips_exec_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input logic             clk,
   input logic             reset,
   mips_exec_unit_if.slave bus
);
   logic [31:0] a, b, res, hi_v, lo_v, tgt;
   logic [31:0] tgt_d, tgt_q;
   logic        delay_d, delay_q;
   assign a = bus.a;
   assign b = bus.b;
`ifdef MIPS_EXEC_MULTDIV_EN
   logic [63:0] smul, umul;
   logic [31:0] sq, sr, uq, ur;
   assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign umul = {32'h0, a} * {32'h0, b};
   assign sq   = $signed(a) / $signed(b);
   assign sr   = $signed(a) % $signed(b);
   assign uq   = a / b;
   assign ur   = a % b;
`endif
   always_comb begin
      res  = '0;
      hi_v = '0;
      lo_v = '0;
      case (bus.alu_op)
         2'b00: res = a + b;
         2'b01: res = a - b;
         2'b10: case (bus.funct)
            6'h21: res = a + b;
            6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h2A: res = {31'h0, $signed(a) < $signed(b)};
            6'h2B: res = {31'h0, a < b};
            6'h00: res = b << bus.shamt;
            6'h02: res = b >> bus.shamt;
            6'h03: res = $signed(b) >>> bus.shamt;
            6'h04: res = b << a[4:0];
            6'h06: res = b >> a[4:0];
            6'h07: res = $signed(b) >>> a[4:0];
`ifdef MIPS_EXEC_MULTDIV_EN
            6'h18: {hi_v, lo_v} = smul;
            6'h19: {hi_v, lo_v} = umul;
            6'h1A: if (b != 32'h0) {hi_v, lo_v} = {sr, sq};
            6'h1B: if (b != 32'h0) {hi_v, lo_v} = {ur, uq};
`endif
            default: res = '0;
         endcase
         default: case (bus.opcode)
            6'h09: res = a + b;
            6'h0A: res = {31'h0, $signed(a) < $signed(b)};
            6'h0B: res = {31'h0, a < b};
            6'h0C: res = a & b;
            6'h0D: res = a | b;
            6'h0E: res = a ^ b;
            6'h0F: res = {b[15:0], 16'h0};
            default: res = '0;
         endcase
      endcase
   end
   assign bus.alu_out = res;
   assign bus.zero    = res == 32'h0;
   assign bus.hi      = hi_v;
   assign bus.lo      = lo_v;
   assign tgt = bus.jump2 ? bus.read_data_a :
                bus.jump1 ? bus.jump_addr :
                bus.condition_met ? bus.branch_addr : bus.pc_plus4;
   assign bus.tgt_addr = tgt;
   // the target captured with a control-flow instruction is applied one instruction later (delay slot)
   always_comb begin
      tgt_d   = bus.clk_enable ? tgt : tgt_q;
      delay_d = bus.clk_enable ? (bus.branch | bus.jump1 | bus.jump2) : delay_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tgt_q   <= RESET_VECTOR;
         delay_q <= 1'b0;
      end else begin
         tgt_q   <= tgt_d;
         delay_q <= delay_d;
      end
   end
   assign bus.pc_next = delay_q ? tgt_q : bus.pc_plus4;
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit: randomized scoreboard bench for mips_exec_unit against a behavioural model
module tb_mips_exec_unit;
   typedef struct {
      logic [31:0] alu, hi, lo, tgt, pc;
      logic        z, chk_pc;
      int          id;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0, errors = 0, n_issued = 0;
   exp_t q[$];
   logic        m_delay = 1'b0, m_known = 1'b0;
   logic [31:0] m_tgt = '0;
   logic [5:0]  fcodes[18] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00,
                               6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h19, 6'h1A, 6'h1B};
   logic [5:0]  ocodes[7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
   mips_exec_unit_if bus();
   mips_exec_unit #(.RESET_VECTOR(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic model_alu(output logic [31:0] r, output logic [31:0] h, output logic [31:0] l);
      int sa, sb;
      longint p;
      longint unsigned pu;
      sa = bus.a; sb = bus.b;
      r = 0; h = 0; l = 0;
      if (bus.alu_op == 2'd0) r = bus.a + bus.b;
      else if (bus.alu_op == 2'd1) r = bus.a - bus.b;
      else if (bus.alu_op == 2'd2) begin
         case (bus.funct)
            6'h21: r = bus.a + bus.b;
            6'h23: r = bus.a - bus.b;
            6'h24: r = bus.a & bus.b;
            6'h25: r = bus.a | bus.b;
            6'h26: r = bus.a ^ bus.b;
            6'h27: r = ~(bus.a | bus.b);
            6'h2A: r = (sa < sb) ? 1 : 0;
            6'h2B: r = (bus.a < bus.b) ? 1 : 0;
            6'h00: r = bus.b << bus.shamt;
            6'h02: r = bus.b >> bus.shamt;
            6'h03: r = sb >>> bus.shamt;
            6'h04: r = bus.b << bus.a[4:0];
            6'h06: r = bus.b >> bus.a[4:0];
            6'h07: r = sb >>> bus.a[4:0];
`ifdef MIPS_EXEC_MULTDIV_EN
            6'h18: begin p = longint'(sa) * longint'(sb); {h, l} = p; end
            6'h19: begin pu = longint'(bus.a) * longint'(bus.b); {h, l} = pu; end
            6'h1A: if (sb != 0) begin l = sa / sb; h = sa % sb; end
            6'h1B: if (bus.b != 0) begin l = bus.a / bus.b; h = bus.a % bus.b; end
`endif
            default: r = 0;
         endcase
      end else begin
         case (bus.opcode)
            6'h09: r = bus.a + bus.b;
            6'h0A: r = (sa < sb) ? 1 : 0;
            6'h0B: r = (bus.a < bus.b) ? 1 : 0;
            6'h0C: r = bus.a & bus.b;
            6'h0D: r = bus.a | bus.b;
            6'h0E: r = bus.a ^ bus.b;
            6'h0F: r = bus.b * 65536;
            default: r = 0;
         endcase
      end
   endtask

   // push the expectation for the current inputs, then advance the model across the next edge
   task automatic issue();
      exp_t e;
      model_alu(e.alu, e.hi, e.lo);
      e.z = (e.alu == 0);
      e.tgt = bus.jump2 ? bus.read_data_a : bus.jump1 ? bus.jump_addr :
              bus.condition_met ? bus.branch_addr : bus.pc_plus4;
      e.pc = m_delay ? m_tgt : bus.pc_plus4;
      e.chk_pc = m_known;
      e.id = n_issued++;
      q.push_back(e);
      @(posedge clk);
      if (reset) begin
         m_delay = 1'b0; m_tgt = 32'h0; m_known = 1'b1;
      end else if (bus.clk_enable) begin
         m_tgt = e.tgt; m_delay = bus.branch | bus.jump1 | bus.jump2;
      end
      #1;
   endtask

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("alu_out", e.id, bus.alu_out, e.alu);
            check("zero", e.id, {31'h0, bus.zero}, {31'h0, e.z});
            check("hi", e.id, bus.hi, e.hi);
            check("lo", e.id, bus.lo, e.lo);
            check("tgt_addr", e.id, bus.tgt_addr, e.tgt);
            if (e.chk_pc) check("pc_next", e.id, bus.pc_next, e.pc);
         end
      end
   end

   task automatic ctl(input logic en, input logic br, input logic cm, input logic j1, input logic j2);
      bus.clk_enable = en; bus.branch = br; bus.condition_met = cm; bus.jump1 = j1; bus.jump2 = j2;
   endtask

   task automatic alu(input logic [1:0] op, input logic [5:0] oc, input logic [5:0] fn,
                      input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv);
      bus.alu_op = op; bus.opcode = oc; bus.funct = fn; bus.shamt = sh; bus.a = av; bus.b = bv;
   endtask

   initial begin : driver
      alu(2'd0, 6'h0, 6'h0, 5'd0, 32'h0, 32'h0);
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.branch_addr = 32'h100; bus.jump_addr = 32'h200; bus.read_data_a = 32'h300; bus.pc_plus4 = 32'h10;
      @(posedge clk); #1;
      reset = 1'b1; bus.clk_enable = 1'b0; issue();
      reset = 1'b0; bus.clk_enable = 1'b1; issue();
      alu(2'd2, 6'h0, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1); issue();
      alu(2'd2, 6'h0, 6'h03, 5'd4, 32'h0, 32'hF000_0000); issue();
      alu(2'd2, 6'h0, 6'h02, 5'd4, 32'h0, 32'hF000_0000); issue();
      alu(2'd2, 6'h0, 6'h18, 5'd0, 32'hFFFF_FFFE, 32'h3); issue();
      alu(2'd2, 6'h0, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'h2); issue();
      alu(2'd2, 6'h0, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'h0); issue();
      alu(2'd2, 6'h0, 6'h1B, 5'd0, 32'h1234_5678, 32'h0); issue();
      alu(2'd3, 6'h0F, 6'h0, 5'd0, 32'h0, 32'h1234); issue();
      alu(2'd3, 6'h0A, 6'h0, 5'd0, 32'hFFFF_FFFF, 32'h0); issue();
      alu(2'd2, 6'h0, 6'h08, 5'd0, 32'h5, 32'h6); issue();
      alu(2'd1, 6'h0, 6'h0, 5'd0, 32'h5, 32'h5); issue();
      ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); bus.pc_plus4 = 32'h1C; issue();
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); bus.pc_plus4 = 32'h20; issue();
      bus.pc_plus4 = 32'h24; issue();
      ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); issue();
      ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); issue();
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); reset = 1'b1; issue();
      reset = 1'b0; bus.pc_plus4 = 32'h28; issue();
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); issue();
      ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); issue();
      issue();
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); issue();
      issue();
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 29) == 0);
         bus.clk_enable = ($urandom_range(0, 6) != 0);
         bus.alu_op = 2'($urandom);
         bus.funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fcodes[$urandom_range(0, 17)];
         bus.opcode = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ocodes[$urandom_range(0, 6)];
         bus.shamt = 5'($urandom);
         bus.a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
         bus.b = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom_range(0, 9) == 0) ? bus.a : $urandom;
         if (bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF) bus.b = 32'h1;
         bus.branch_addr = $urandom; bus.jump_addr = $urandom;
         bus.read_data_a = $urandom; bus.pc_plus4 = $urandom;
         bus.condition_met = ($urandom_range(0, 2) == 0);
         bus.branch = ($urandom_range(0, 2) == 0);
         bus.jump1 = ($urandom_range(0, 4) == 0);
         bus.jump2 = ($urandom_range(0, 4) == 0);
         issue();
      end
      reset = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
